// File: rtl/router_mp_pkg.sv
// Shared types and CSR address map for the multi-port packet router.
package router_mp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        XMIT,
        DROP
    } state_t;

    localparam logic [7:0] ADDR_CTRL     = 8'h00;
    localparam logic [7:0] ADDR_PORT_EN  = 8'h01;
    localparam logic [7:0] ADDR_PKT_CNT  = 8'h02;
    localparam logic [7:0] ADDR_DROP_CNT = 8'h03;
    localparam logic [7:0] ADDR_OUT_BASE = 8'h10;

    localparam int CTRL_EN_BIT = 0;

endpackage

// File: rtl/router_mp_csr.sv
// CSR slave for router_mp: global/per-port enables, packet/drop/per-port counters
// and a registered read port.
module router_mp_csr
    import router_mp_pkg::*;
#(
    parameter int NUM_PORTS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr,
    input  logic                 rd,
    input  logic [7:0]           addr,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata,
    input  logic                 pkt_inc,
    input  logic                 drop_inc,
    input  logic [NUM_PORTS-1:0] out_inc,
    output logic                 en,
    output logic [NUM_PORTS-1:0] port_en
);

    logic [31:0] pkt_cnt;
    logic [31:0] drop_cnt;
    logic [31:0] out_cnt [NUM_PORTS];
    logic [31:0] rd_mux;
    logic        wdata_unused;

    assign wdata_unused = ^wdata;

    always_comb begin
        rd_mux = '0;
        case (addr)
            ADDR_CTRL:     rd_mux[CTRL_EN_BIT] = en;
            ADDR_PORT_EN:  rd_mux[NUM_PORTS-1:0] = port_en;
            ADDR_PKT_CNT:  rd_mux = pkt_cnt;
            ADDR_DROP_CNT: rd_mux = drop_cnt;
            default:       ;
        endcase
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (addr == ADDR_OUT_BASE + 8'(p)) rd_mux = out_cnt[p];
        end
    end

    // Read mux samples pre-edge state, so a same-cycle write returns the old value.
    always_ff @(posedge clk) begin
        if (reset) begin
            en       <= 1'b1;
            port_en  <= '1;
            pkt_cnt  <= '0;
            drop_cnt <= '0;
            rdata    <= '0;
            for (int unsigned p = 0; p < NUM_PORTS; p++) out_cnt[p] <= '0;
        end else begin
            if (wr && addr == ADDR_CTRL)    en      <= wdata[CTRL_EN_BIT];
            if (wr && addr == ADDR_PORT_EN) port_en <= wdata[NUM_PORTS-1:0];

            if (wr && addr == ADDR_PKT_CNT) pkt_cnt <= '0;
            else if (pkt_inc)               pkt_cnt <= pkt_cnt + 32'd1;

            if (wr && addr == ADDR_DROP_CNT) drop_cnt <= '0;
            else if (drop_inc)               drop_cnt <= drop_cnt + 32'd1;

            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                if (wr && addr == ADDR_OUT_BASE + 8'(p)) out_cnt[p] <= '0;
                else if (out_inc[p])                     out_cnt[p] <= out_cnt[p] + 32'd1;
            end

            if (rd) rdata <= rd_mux;
        end
    end

endmodule

// File: rtl/router_mp.sv
// Multi-port packet router: buffers one word-serial packet, then replays it on the
// output channel selected by the header word.
module router_mp
    import router_mp_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int NUM_PORTS = 4,
    parameter int DEPTH     = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           dut_inp,
    input  logic                       inp_valid,
    output logic [NUM_PORTS*WIDTH-1:0] dut_outp,
    output logic [NUM_PORTS-1:0]       outp_valid,
    output logic                       busy,
    output logic                       error,
    input  logic                       wr,
    input  logic                       rd,
    input  logic [7:0]                 addr,
    input  logic [31:0]                wdata,
    output logic [31:0]                rdata
);

    localparam int PW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int NP2 = 2 ** PW;
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW  = $clog2(DEPTH + 1);

    state_t                     state, state_nx;
    logic                       inp_valid_q;
    logic                       rise;
    logic [PW-1:0]              hdr_dest;
    logic [PW-1:0]              dest;
    logic [WIDTH-1:0]           buf_mem [DEPTH];
    logic [LW-1:0]              len;
    logic [LW-1:0]              rd_idx;
    logic                       drop_pend;
    logic                       en;
    logic [NUM_PORTS-1:0]       port_en;
    logic [NP2-1:0]             port_en_ext;
    logic                       hdr_ok;
    logic                       last_word;
    logic                       capture;
    logic                       store;
    logic                       err_nx;
    logic                       pkt_inc;
    logic [NUM_PORTS-1:0]       out_inc;
    logic [NUM_PORTS-1:0]       dest_mask;
    logic [NUM_PORTS*WIDTH-1:0] lane_data;

    assign rise      = inp_valid & ~inp_valid_q;
    assign hdr_dest  = dut_inp[PW-1:0];
    // Zero-padded enable vector makes out-of-range destinations read as disabled.
    assign port_en_ext = NP2'(port_en);
    assign hdr_ok    = en & port_en_ext[hdr_dest];
    assign last_word = (rd_idx == len - LW'(1));

    always_comb begin
        dest_mask = '0;
        lane_data = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (dest == PW'(p)) begin
                dest_mask[p] = 1'b1;
                lane_data[p*WIDTH +: WIDTH] = buf_mem[rd_idx[AW-1:0]];
            end
        end
    end

    always_comb begin
        state_nx = state;
        err_nx   = 1'b0;
        pkt_inc  = 1'b0;
        capture  = 1'b0;
        store    = 1'b0;
        out_inc  = '0;
        case (state)
            IDLE: begin
                if (rise) begin
                    if (hdr_ok) begin
                        capture  = 1'b1;
                        pkt_inc  = 1'b1;
                        state_nx = RECV;
                    end else begin
                        err_nx   = 1'b1;
                        state_nx = DROP;
                    end
                end
            end
            RECV: begin
                if (!inp_valid) begin
                    state_nx = XMIT;
                end else if (len == LW'(DEPTH)) begin
                    err_nx   = 1'b1;
                    state_nx = DROP;
                end else begin
                    store = 1'b1;
                end
            end
            XMIT: begin
                err_nx = rise;
                if (last_word) begin
                    out_inc  = dest_mask;
                    // An intruding packet still on the wire must be drained first.
                    state_nx = ((drop_pend | rise) & inp_valid) ? DROP : IDLE;
                end
            end
            DROP: begin
                if (!inp_valid) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (capture)    buf_mem[0]             <= dut_inp;
        else if (store) buf_mem[len[AW-1:0]]   <= dut_inp;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inp_valid_q <= 1'b0;
            dest        <= '0;
            len         <= '0;
            rd_idx      <= '0;
            drop_pend   <= 1'b0;
            outp_valid  <= '0;
            dut_outp    <= '0;
            busy        <= 1'b0;
            error       <= 1'b0;
        end else begin
            inp_valid_q <= inp_valid;
            error       <= err_nx;
            busy        <= (state == XMIT);
            outp_valid  <= (state == XMIT) ? dest_mask : '0;
            dut_outp    <= (state == XMIT) ? lane_data : '0;

            if (state == XMIT && rise) drop_pend <= 1'b1;
            else if (!inp_valid)       drop_pend <= 1'b0;

            if (capture) begin
                dest <= hdr_dest;
                len  <= LW'(1);
            end else if (store) begin
                len  <= len + LW'(1);
            end

            if (state == RECV && !inp_valid) rd_idx <= '0;
            else if (state == XMIT)          rd_idx <= rd_idx + LW'(1);
        end
    end

    router_mp_csr #(
        .NUM_PORTS(NUM_PORTS)
    ) u_csr (
        .clk     (clk),
        .reset   (reset),
        .wr      (wr),
        .rd      (rd),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .pkt_inc (pkt_inc),
        .drop_inc(err_nx),
        .out_inc (out_inc),
        .en      (en),
        .port_en (port_en)
    );

endmodule

// File: tb/tb_router_mp.sv
// Directed scoreboard bench for router_mp: expected words are queued as packets are
// driven and matched against channel output by a negedge monitor.
module tb_router_mp;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  dut_inp = '0;
    logic        inp_valid = 1'b0;
    logic [31:0] dut_outp;
    logic [3:0]  outp_valid;
    logic        busy;
    logic        error;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic [7:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;

    typedef struct {
        int         port;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_mis = 0;
    int   err_seen = 0;
    int   busy_seen = 0;

    always #5 clk = ~clk;

    router_mp #(
        .WIDTH    (8),
        .NUM_PORTS(4),
        .DEPTH    (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .dut_inp   (dut_inp),
        .inp_valid (inp_valid),
        .dut_outp  (dut_outp),
        .outp_valid(outp_valid),
        .busy      (busy),
        .error     (error),
        .wr        (wr),
        .rd        (rd),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Word 0 is the header; body words are base, base+0x11, base+0x22, ...
    task automatic send(input logic [7:0] hdr, input int n, input logic [7:0] base, input bit fwd);
        for (int i = 0; i < n; i++) begin
            logic [7:0] w;
            w = (i == 0) ? hdr : base + 8'((i - 1) * 17);
            if (fwd) sb.push_back('{int'(hdr[1:0]), w});
            dut_inp   = w;
            inp_valid = 1'b1;
            tick();
        end
        inp_valid = 1'b0;
        dut_inp   = '0;
    endtask

    task automatic csr_write(input logic [7:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wr    = 1'b1;
        tick();
        wr = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
        addr = a;
        rd   = 1'b1;
        tick();
        rd = 1'b0;
        check(tag, 64'(rdata), 64'(exp));
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (error === 1'b1) err_seen++;
        if (busy === 1'b1) busy_seen++;
        if (outp_valid !== '0) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 64'(outp_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                check("out_valid", 64'(outp_valid), 64'(4'b0001 << e.port));
                check("out_data", 64'(dut_outp), 64'(32'(e.data) << (8 * e.port)));
                check("busy_with_valid", 64'(busy), 64'd1);
            end
        end else begin
            check("idle_lanes", 64'({busy, dut_outp}), 64'd0);
        end
    end

    initial begin
        int e0;
        int b0;

        tick();
        tick();
        check("rst_valid", 64'(outp_valid), 64'd0);
        check("rst_data", 64'(dut_outp), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_rdata", 64'(rdata), 64'd0);
        reset = 1'b0;
        tick();
        rd_chk("rst_ctrl", 8'h00, 32'h1);
        rd_chk("rst_port_en", 8'h01, 32'hF);
        rd_chk("rst_pkt_cnt", 8'h02, 32'h0);

        // 3-word packet to channel 2, with exact first-output latency.
        b0 = busy_seen;
        send(8'h02, 3, 8'hAA, 1'b1);
        tick();
        check("lat_before", 64'(outp_valid), 64'd0);
        tick();
        check("lat_first", 64'(outp_valid), 64'h4);
        check("lat_busy", 64'(busy), 64'd1);
        repeat (5) tick();
        check("busy_cycles_3", 64'(busy_seen - b0), 64'd3);
        rd_chk("pkt_cnt_1", 8'h02, 32'd1);
        rd_chk("out_cnt2_1", 8'h12, 32'd1);

        // Disabled port drops, re-enabled port forwards.
        csr_write(8'h01, 32'hD);
        e0 = err_seen;
        send(8'h01, 2, 8'h55, 1'b0);
        repeat (4) tick();
        check("port_dis_err", 64'(err_seen - e0), 64'd1);
        rd_chk("drop_cnt_1", 8'h03, 32'd1);
        csr_write(8'h01, 32'hF);
        send(8'h01, 3, 8'h11, 1'b1);
        repeat (6) tick();
        rd_chk("out_cnt1_1", 8'h11, 32'd1);

        // Overlong packet is dropped; the next one is intact.
        e0 = err_seen;
        send(8'h00, 17, 8'h30, 1'b0);
        repeat (4) tick();
        check("overflow_err", 64'(err_seen - e0), 64'd1);
        send(8'h03, 2, 8'h44, 1'b1);
        repeat (6) tick();
        rd_chk("out_cnt0_0", 8'h10, 32'd0);
        rd_chk("out_cnt3_1", 8'h13, 32'd1);

        // Global disable drops.
        csr_write(8'h00, 32'h0);
        e0 = err_seen;
        send(8'h02, 2, 8'h60, 1'b0);
        repeat (4) tick();
        check("ctrl_dis_err", 64'(err_seen - e0), 64'd1);
        csr_write(8'h00, 32'h1);
        rd_chk("ctrl_back_on", 8'h00, 32'h1);
        rd_chk("drop_cnt_3", 8'h03, 32'd3);
        csr_write(8'h03, 32'h0);
        rd_chk("drop_cnt_clr", 8'h03, 32'd0);

        // Second packet starting during transmission of the first.
        e0 = err_seen;
        b0 = busy_seen;
        send(8'h01, 4, 8'h10, 1'b1);
        tick();
        tick();
        send(8'h02, 5, 8'h77, 1'b0);
        repeat (8) tick();
        check("xmit_overlap_err", 64'(err_seen - e0), 64'd1);
        check("busy_cycles_4", 64'(busy_seen - b0), 64'd4);
        rd_chk("drop_cnt_overlap", 8'h03, 32'd1);
        rd_chk("out_cnt1_2", 8'h11, 32'd2);

        // Single-word packet.
        b0 = busy_seen;
        send(8'h03, 1, 8'h00, 1'b1);
        repeat (5) tick();
        check("busy_cycles_1", 64'(busy_seen - b0), 64'd1);
        rd_chk("out_cnt3_2", 8'h13, 32'd2);

        // Clear of PKT_CNT coincides with its increment.
        sb.push_back('{0, 8'h00});
        sb.push_back('{0, 8'h5A});
        addr      = 8'h02;
        wdata     = '0;
        wr        = 1'b1;
        dut_inp   = 8'h00;
        inp_valid = 1'b1;
        tick();
        wr      = 1'b0;
        dut_inp = 8'h5A;
        tick();
        inp_valid = 1'b0;
        dut_inp   = '0;
        repeat (5) tick();
        rd_chk("pkt_clr_wins", 8'h02, 32'd0);
        rd_chk("out_cnt0_1", 8'h10, 32'd1);

        // Simultaneous write and read of the same counter returns the old value.
        addr = 8'h03;
        wr   = 1'b1;
        rd   = 1'b1;
        tick();
        wr = 1'b0;
        rd = 1'b0;
        check("wr_rd_old", 64'(rdata), 64'd1);
        rd_chk("wr_rd_cleared", 8'h03, 32'd0);
        rd_chk("unmapped_7f", 8'h7F, 32'd0);
        rd_chk("unmapped_14", 8'h14, 32'd0);
        csr_write(8'h7F, 32'hFFFF_FFFF);
        rd_chk("unmapped_wr_ignored", 8'h01, 32'hF);

        // Reset in the middle of a transmission.
        send(8'h01, 6, 8'h90, 1'b1);
        tick();
        tick();
        check("pre_rst_valid", 64'(outp_valid), 64'h2);
        reset = 1'b1;
        tick();
        check("midrst_valid", 64'(outp_valid), 64'd0);
        check("midrst_data", 64'(dut_outp), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_error", 64'(error), 64'd0);
        check("midrst_rdata", 64'(rdata), 64'd0);
        reset = 1'b0;
        sb.delete();
        repeat (4) tick();
        rd_chk("post_rst_pkt_cnt", 8'h02, 32'd0);
        send(8'h02, 2, 8'hC0, 1'b1);
        repeat (6) tick();
        rd_chk("post_rst_out_cnt2", 8'h12, 32'd1);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/router_mp.md
# router_mp

Parametrised multi-port successor to the single-output CSR router. Accepts word-serial packets on one input stream and buffers each one. It then forwards the whole packet on one of `NUM_PORTS` output channels, chosen by the header word. A CSR slave provides global and per-port enables plus packet, drop and per-port counters. The block sits between the stimulus interface and the output channel monitors, in place of the single-port router.

## Interface
- `WIDTH`, 8: data word width (≥ 4).
- `NUM_PORTS`, 4: output channels (2..8); `PW = $clog2(NUM_PORTS)`.
- `DEPTH`, 16: packet buffer words (maximum packet length, header included).
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `dut_inp`  in  WIDTH  input word.
- `inp_valid`  in  1  high for every word of a packet; a low level ends the packet.
- `dut_outp`  out  NUM_PORTS*WIDTH  channel p occupies bits [p*WIDTH +: WIDTH].
- `outp_valid`  out  NUM_PORTS  per-channel word valid.
- `busy`  out  1  high while transmitting.
- `error`  out  1  one-cycle pulse per dropped packet.
- `wr`, `rd`  in  1 each  CSR write and read strobes.
- `addr`  in  8  CSR word address.
- `wdata`  in  32  CSR write data.
- `rdata`  out  32  CSR read data.

## Operation
- Header is the first word. Destination `dest = dut_inp[PW-1:0]`. The header is stored and forwarded as word 0.
- FSM states:
  - IDLE: a rising edge of `inp_valid` (`inp_valid & !inp_valid_q`) means a header is present. If the header is legal, capture it and go to RECV. If it is illegal (CTRL.EN=0, `dest ≥ NUM_PORTS`, or PORT_EN[dest]=0), pulse `error` and go to DROP.
  - RECV: store one word per cycle while `inp_valid` is high.
    - `inp_valid` low: go to XMIT with `len` = number of stored words.
    - A word arrives when `len==DEPTH`: pulse `error` and go to DROP; the buffer is discarded.
  - XMIT: drive `buf[i]` on channel `dest` with `outp_valid[dest]=1` for `len` consecutive cycles. Then go to DROP if `drop_pend` is set, otherwise go to IDLE.
  - DROP: ignore input until `inp_valid` is low, then go to IDLE.
- Input arriving during XMIT (a rising edge of `inp_valid`): pulse `error`, increment DROP_CNT and set `drop_pend`. `drop_pend` clears when `inp_valid` is sampled low.
- Counters are 32-bit and wrap.
  - PKT_CNT increments on entry to RECV.
  - DROP_CNT increments with every `error` pulse.
  - OUT_CNT[p] increments on the last XMIT word.
- CSR map (word addresses):
  - 0x00 CTRL: bit0 EN, reset value 1.
  - 0x01 PORT_EN: bits [NUM_PORTS-1:0], reset value all ones.
  - 0x02 PKT_CNT, 0x03 DROP_CNT, 0x10+p OUT_CNT[p].
  - Writing any counter address clears that counter.
  - Unmapped addresses read 0; writes to them are ignored.
- CTRL and PORT_EN changes affect only headers that arrive later. A packet already in RECV or XMIT completes.

## Timing
- Reset values: `outp_valid=0`, `dut_outp=0`, `busy=0`, `error=0`, `rdata=0`, counters 0, FSM in IDLE, `drop_pend=0`. Reset mid-packet abandons the packet without an error pulse.
- Input sampling: header sampled at edge T0. Last word at edge T0+len-1. `inp_valid` sampled low at edge T0+len.
- Output: first output word is valid in the cycle after edge T0+len+1, then `len` cycles. Idle-to-first-output latency is 2 cycles after end of packet.
- `busy` equals state==XMIT, aligned exactly with `outp_valid`.
- Non-destination channels hold `outp_valid=0` and `dut_outp` lanes at 0.
- `error` is asserted the cycle after the offending sample edge.
- CSR read: `rd` sampled at edge N, `rdata` valid after edge N and held until the next read.
- CSR write takes effect at the sampling edge.
- Simultaneous `wr` and `rd` to the same address: `rdata` returns the old value.
- Counter clear and increment in the same cycle: clear wins, result 0.

## Structure
- `router_mp_pkg`: FSM state enum (IDLE, RECV, XMIT, DROP), CSR address constants, CTRL bit index.
- `router_mp_csr`: register file, counters and read mux. The core sends it increment strobes and receives EN and PORT_EN.
- Top level: FSM, buffer (`DEPTH` × `WIDTH` register array), length and read counters, output steering.

## Test plan
- 3-word packet `{0x02,0xAA,0xBB}` → channel 2 outputs 02,AA,BB on consecutive cycles starting 2 cycles after `inp_valid` falls. `busy` high 3 cycles. PKT_CNT=1, OUT_CNT[2]=1.
- Header 0x01 with PORT_EN written to 0xD → `error` pulse, no output on any channel, DROP_CNT=1. Then write PORT_EN=0xF; the next 0x01 packet is forwarded.
- 17-word packet with DEPTH=16 → `error` on the 17th word, no output. The next legal packet is forwarded intact.
- New packet starts during XMIT of a 4-word packet → `error` pulse, the first packet completes unchanged, the second produces no output, DROP_CNT=1.
- 1-word packet 0x03 → single word on channel 3, `busy` high 1 cycle.
- Write 0x02 while PKT_CNT is incrementing → read returns 0. Read 0x7F returns 0. `reset` asserted mid-XMIT → all outputs 0 on the next cycle.
